// File: rtl/chip8_prog_loader.sv
// rtl/chip8_prog_loader.sv - packs a length-prefixed byte stream into 16-bit words for instruction memory
// Optional CHIP8_LOADER_CHECKSUM_EN adds a trailing modulo-256 data checksum byte.
module chip8_prog_loader #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  input  logic              load_start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic              load_error
);

  localparam logic [2:0] S_LEN_HI  = 3'd0;
  localparam logic [2:0] S_LEN_LO  = 3'd1;
  localparam logic [2:0] S_DATA_HI = 3'd2;
  localparam logic [2:0] S_DATA_LO = 3'd3;
  localparam logic [2:0] S_WRITE   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;
  localparam logic [2:0] S_ERROR   = 3'd6;
`ifdef CHIP8_LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CHK     = 3'd7;
  localparam logic [2:0] S_FINISH  = S_CHK;
`else
  localparam logic [2:0] S_FINISH  = S_DONE;
`endif

  localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_WORDS = 17'd1 << (ADDR_W - 1);

  logic [2:0]        state;
  logic [7:0]        len_hi_q;
  logic [15:0]       len_q;
  logic [7:0]        data_hi_q;
  logic [ADDR_W-1:0] word_index;
  logic [TW-1:0]     tmo_cnt;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       mem_wdata_q;
`ifdef CHIP8_LOADER_CHECKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic        xfer;
  logic        tmo_active;
  logic        tmo_hit;
  logic [15:0] len_next;
  logic        last_word;

  always_comb begin
    byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                 (state == S_DATA_HI) || (state == S_DATA_LO);
    tmo_active = (state == S_LEN_LO) || (state == S_DATA_HI) || (state == S_DATA_LO);
`ifdef CHIP8_LOADER_CHECKSUM_EN
    byte_ready = byte_ready || (state == S_CHK);
    tmo_active = tmo_active || (state == S_CHK);
`endif
    xfer      = byte_valid && byte_ready;
    tmo_hit   = tmo_active && !xfer && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    len_next  = {len_hi_q, byte_data};
    last_word = (16'(word_index) + 16'd1) == len_q;
  end

  assign mem_we     = (state == S_WRITE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign load_done  = (state == S_DONE);
  assign cpu_run    = (state == S_DONE);
  assign load_error = (state == S_ERROR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_LEN_HI;
      len_hi_q    <= '0;
      len_q       <= '0;
      data_hi_q   <= '0;
      word_index  <= '0;
      tmo_cnt     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef CHIP8_LOADER_CHECKSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      // Timer restarts on every accepted byte and sits at zero outside byte-wait states.
      if (tmo_active && !xfer && !tmo_hit)
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;

      case (state)
        S_LEN_HI: begin
          if (xfer) begin
            len_hi_q <= byte_data;
            state    <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len_q <= len_next;
            if ({1'b0, len_next} > MAX_WORDS)
              state <= S_ERROR;
            else if (len_next == 16'd0)
              state <= S_FINISH;
            else
              state <= S_DATA_HI;
          end else if (tmo_hit) begin
            state <= S_ERROR;
          end
        end
        S_DATA_HI: begin
          if (xfer) begin
            data_hi_q <= byte_data;
`ifdef CHIP8_LOADER_CHECKSUM_EN
            sum_q     <= sum_q + byte_data;
`endif
            state     <= S_DATA_LO;
          end else if (tmo_hit) begin
            state <= S_ERROR;
          end
        end
        S_DATA_LO: begin
          if (xfer) begin
            mem_wdata_q <= {data_hi_q, byte_data};
            mem_addr_q  <= {word_index[ADDR_W-2:0], 1'b0};
`ifdef CHIP8_LOADER_CHECKSUM_EN
            sum_q       <= sum_q + byte_data;
`endif
            state       <= S_WRITE;
          end else if (tmo_hit) begin
            state <= S_ERROR;
          end
        end
        S_WRITE: begin
          word_index <= word_index + 1'b1;
          state      <= last_word ? S_FINISH : S_DATA_HI;
        end
`ifdef CHIP8_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer)
            state <= (byte_data == sum_q) ? S_DONE : S_ERROR;
          else if (tmo_hit)
            state <= S_ERROR;
        end
`endif
        S_DONE, S_ERROR: begin
          if (load_start) begin
            word_index <= '0;
`ifdef CHIP8_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
            state      <= S_LEN_HI;
          end
        end
        default: state <= S_LEN_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_chip8_prog_loader.sv
// tb/tb_chip8_prog_loader.sv - directed and randomized checks of chip8_prog_loader against an image-level model
// Honours CHIP8_LOADER_CHECKSUM_EN by appending checksum bytes and running the bad-checksum case.
module tb_chip8_prog_loader;
  localparam int AW  = 8;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    byte_data;
  logic          byte_valid;
  logic          byte_ready;
  logic          load_start;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          cpu_run;
  logic          load_done;
  logic          load_error;

  chip8_prog_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .load_start(load_start), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_run(cpu_run),
    .load_done(load_done), .load_error(load_error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          ready_bad = 0;
  bit          rand_gap = 0;
  logic [23:0] wr_q[$];

  // Every write strobe is logged as {addr, data}; the loader must not accept bytes while writing.
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      wr_q.push_back({mem_addr, mem_wdata});
      if (byte_ready) ready_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (rand_gap) begin
      repeat ($urandom_range(0, 3)) begin
        byte_data = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (byte_ready) break;
      n++;
      if (n > 20) begin
        check("handshake_bound", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic send_q(input logic [7:0] s[$]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!(load_done || load_error) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, 32'(load_done || load_error), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic rearm();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  // Image-level model: length header, big-endian word pairs, optional byte-sum trailer.
  task automatic make_image(input logic [15:0] w[$], output logic [7:0] s[$], output logic [23:0] e[$]);
    int sum = 0;
    s = {};
    e = {};
    s.push_back(8'(w.size() / 256));
    s.push_back(8'(w.size() % 256));
    foreach (w[i]) begin
      s.push_back(w[i][15:8]);
      s.push_back(w[i][7:0]);
      sum = (sum + int'(w[i][15:8]) + int'(w[i][7:0])) % 256;
      e.push_back({8'(2 * i), w[i]});
    end
`ifdef CHIP8_LOADER_CHECKSUM_EN
    s.push_back(8'(sum));
`endif
  endtask

  task automatic check_writes(input string tag, input logic [23:0] e[$]);
    check({tag, "_count"}, 32'(wr_q.size()), 32'(e.size()));
    foreach (e[i])
      if (i < wr_q.size()) check($sformatf("%s_word%0d", tag, i), 32'(wr_q[i]), 32'(e[i]));
  endtask

  logic [15:0] words[$];
  logic [7:0]  strm[$];
  logic [23:0] expw[$];

  initial begin
    rst_n = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; load_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(byte_ready), 32'd1);
    check("rst_outs", {25'd0, mem_we, cpu_run, load_done, load_error, 3'd0}, 32'd0);
    check("rst_addr_data", {8'd0, mem_addr, mem_wdata}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two-word image
    words = '{16'h600A, 16'h7001};
    make_image(words, strm, expw);
    wr_q = {};
    send_q(strm);
    wait_end("two_word");
    check_writes("two_word", expw);
    check("two_word_status", {29'd0, load_done, cpu_run, load_error}, 32'b110);

    // Empty image
    rearm();
    check("rearm_clears", {29'd0, load_done, cpu_run, load_error}, 32'd0);
    words = {};
    make_image(words, strm, expw);
    wr_q = {};
    send_q(strm);
    wait_end("empty");
    check_writes("empty", expw);
    check("empty_status", {29'd0, load_done, cpu_run, load_error}, 32'b110);

    // Oversized length, then recovery
    rearm();
    strm = '{8'h00, 8'h81};
    wr_q = {};
    send_q(strm);
    wait_end("oversize");
    check("oversize_status", {28'd0, load_done, cpu_run, load_error, byte_ready}, 32'b0010);
    check("oversize_no_write", 32'(wr_q.size()), 32'd0);
    rearm();
    words = '{16'h1200};
    make_image(words, strm, expw);
    send_q(strm);
    wait_end("recover");
    check_writes("recover", expw);
    check("recover_done", 32'(load_done), 32'd1);

    // Stall mid-word until the timeout fires
    rearm();
    strm = '{8'h00, 8'h01, 8'h12};
    wr_q = {};
    send_q(strm);
    repeat (8) @(posedge clk);
    #1;
    check("tmo_not_yet", 32'(load_error), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check("tmo_error", {30'd0, load_error, cpu_run}, 32'b10);
    check("tmo_no_write", 32'(wr_q.size()), 32'd0);

    // Full-capacity image with random source gaps
    rearm();
    words = {};
    for (int i = 0; i < 128; i++) words.push_back(16'($urandom));
    make_image(words, strm, expw);
    wr_q = {};
    ready_bad = 0;
    rand_gap = 1;
    send_q(strm);
    rand_gap = 0;
    wait_end("full");
    check_writes("full", expw);
    check("full_ready_low_in_write", 32'(ready_bad), 32'd0);
    check("full_status", {29'd0, load_done, cpu_run, load_error}, 32'b110);

`ifdef CHIP8_LOADER_CHECKSUM_EN
    rearm();
    strm = '{8'h00, 8'h01, 8'hA1, 8'h23, 8'h00};
    wr_q = {};
    send_q(strm);
    wait_end("bad_sum");
    expw = '{24'h00A123};
    check_writes("bad_sum", expw);
    check("bad_sum_status", {29'd0, load_done, cpu_run, load_error}, 32'b001);
`endif

    // Asynchronous reset in the middle of a load
    rearm();
    strm = '{8'h00, 8'h02, 8'h11};
    send_q(strm);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ready", 32'(byte_ready), 32'd1);
    check("async_rst_outs", {28'd0, mem_we, cpu_run, load_done, load_error}, 32'd0);
    check("async_rst_addr_data", {8'd0, mem_addr, mem_wdata}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/chip8_prog_loader.md
Name: chip8_prog_loader

Overview:
- Upstream stage of the CPU's instruction memory: receives a program as a byte stream, packs big-endian byte pairs into 16-bit instruction words and writes them into the instruction ROM/RAM.
- Holds the CPU stopped (cpu_run low) until a complete, valid image has been written.
- Memory is byte-addressed with word-aligned addresses, matching the CPU fetch, whose program counter steps by 2.

Parameters:
- ADDR_W, 8, width of memory address; image capacity is 2^(ADDR_W-1) words.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between accepted bytes once a load has begun.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- byte_data  input  8  incoming stream byte.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_ready  output  1  loader accepts byte_data this cycle; transfer occurs when byte_valid and byte_ready are both high.
- load_start  input  1  single-cycle re-arm request; honoured only in DONE or ERROR.
- mem_we  output  1  instruction memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  byte address of the write (always even).
- mem_wdata  output  16  instruction word, {high byte, low byte}.
- cpu_run  output  1  high releases the CPU; low holds it.
- load_done  output  1  level; image loaded successfully.
- load_error  output  1  level; load aborted.

Behaviour:
- Reset (async, rst_n low):
  - State LEN_HI.
  - byte_ready=1; mem_we=0; mem_addr=0; mem_wdata=0; cpu_run=0; load_done=0; load_error=0.
  - Word counter, length register and timeout counter cleared.
- Reset mid-load discards the partial image. Memory contents are not cleared.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N pairs DATA_HI, DATA_LO.
- States:
  - LEN_HI: byte_ready=1. On transfer, latch the length high byte and go to LEN_LO.
  - LEN_LO: byte_ready=1. On transfer, form N.
    - N > 2^(ADDR_W-1): go to ERROR.
    - N = 0: go to DONE (or CHK when CHECKSUM_EN is defined).
    - Otherwise: go to DATA_HI.
  - DATA_HI: byte_ready=1. On transfer, latch the high byte and go to DATA_LO.
  - DATA_LO: byte_ready=1. On transfer, latch the low byte and go to WRITE.
  - WRITE: byte_ready=0; mem_we=1 for exactly one cycle.
    - mem_wdata = {hi, lo}; mem_addr = 2 × word_index (ADDR_W bits).
    - word_index increments. If word_index+1 == N, go to DONE (or CHK); otherwise go to DATA_HI.
    - Write latency: mem_we asserts in the cycle after the DATA_LO transfer.
  - DONE: byte_ready=0; load_done=1; cpu_run=1.
  - ERROR: byte_ready=0; load_error=1; cpu_run=0.
- Re-arm: load_start in DONE or ERROR returns to LEN_HI on the next edge.
  - Clears load_done, load_error, cpu_run, word_index and the checksum.
  - load_start in any other state is ignored.
- Timeout:
  - Counter is active in LEN_LO, DATA_HI, DATA_LO and CHK.
  - Cleared on every transfer and in every other state.
  - Reaching TIMEOUT_CYCLES-1 without a transfer forces ERROR.
  - LEN_HI waits indefinitely.
- Bytes presented while byte_ready=0 are not consumed. The source must hold them.
- Address wrap cannot occur: the length check bounds the top address at 2^ADDR_W-2.
- mem_addr and mem_wdata hold their last values when mem_we=0.

Optional Feature:
- Macro: CHIP8_LOADER_CHECKSUM_EN.
- Defined:
  - The loader keeps an 8-bit modulo-256 sum of all DATA bytes, excluding the length bytes.
  - After the last WRITE (or after LEN_LO when N=0) it enters state CHK with byte_ready=1.
  - The next transferred byte is compared with the sum: equal goes to DONE; unequal goes to ERROR.
  - Words already written stay in memory, but cpu_run stays 0.
- Undefined: state CHK and the sum logic are absent; the last WRITE goes directly to DONE.

Test Plan:
- Reset, then stream 00 02 60 0A 70 01 (plus checksum 0xDB if enabled) → mem writes 0x600A at addr 0x00 and 0x7001 at addr 0x02, one mem_we each; then load_done=1, cpu_run=1, load_error=0.
- Stream 00 00 (plus checksum 00 if enabled) → no mem_we pulses; DONE reached; cpu_run=1.
- With ADDR_W=8, stream 00 81 → ERROR; load_error=1, cpu_run=0, byte_ready=0. Then pulse load_start, send 00 01 12 00 (plus checksum 0x12) → addr 0x00 = 0x1200 and DONE.
- TIMEOUT_CYCLES=16: send 00 01 12, then hold byte_valid low for 16 cycles → ERROR; no mem_we ever asserted.
- Toggle byte_valid randomly during a 128-word load → every word written exactly once at addresses 0x00…0xFE in order; byte_ready low during each WRITE cycle; no byte lost or duplicated.
- CHECKSUM_EN defined: stream 00 01 A1 23 with wrong checksum 0x00 → addr 0x00 written with 0xA123, then ERROR with cpu_run=0. Assert rst_n low mid-stream in a second load → all outputs return to reset values immediately, without waiting for a clock edge.
